uart_rx_gen: RTL and testbench

UART_RX_GEN -- requirements
Module: uart_rx_gen

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx_gen.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = 4;
  localparam int unsigned IDX_W      = 4;

  // ST_BREAK holds after a framing error until the line returns high.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE   = 2'd0,
    PAR_EVEN   = 2'd1,
    PAR_ODD    = 2'd2,
    PAR_NONE_3 = 2'd3
  } parity_mode_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample enable generator: one-cycle tick every CLK_HZ/(BAUD*16) clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o
);

  localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Divider counter wraps at DIV-1 and flags the wrap as the tick.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Divider state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_gen.sv
// 16x oversampling UART receiver with valid/ready output and overrun flag.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 CLK50MHz,
  input  logic                 RESET,
  input  logic                 RX,
  input  logic [1:0]           PARITY_MODE,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DATA_VALID,
  input  logic                 DATA_READY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  logic                 baud_tick;
  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 perr_acc_q, perr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 mid_c, done_c, hs_c, par_on_c;

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_baud_tick (
    .clk_i   (CLK50MHz),
    .rst_n_i (RESET),
    .tick_o  (baud_tick)
  );

  assign rx_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
  assign par_on_c = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^PARITY_MODE;
  assign par_on_c = 1'b0;
`endif

  // Frame FSM, then output/handshake register next-state.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    ferr_acc_d = ferr_acc_q;
    perr_acc_d = perr_acc_q;
    done_c     = 1'b0;
    mid_c      = baud_tick && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

    case (state_q)
      ST_IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          if (tick_cnt_q == TICK_W'(OVERSAMPLE / 2 - 1)) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d    = ST_DATA;
              bit_idx_d  = '0;
              ferr_acc_d = 1'b0;
              perr_acc_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) tick_cnt_d = tick_cnt_q + TICK_W'(1);
        if (mid_c) begin
          shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = par_on_c ? ST_PARITY : ST_STOP;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) tick_cnt_d = tick_cnt_q + TICK_W'(1);
        if (mid_c) begin
          // Even: parity bit equals XOR of data; odd: its inverse.
          perr_acc_d = rx_s ^ (^shreg_q) ^ (PARITY_MODE == PAR_ODD);
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_tick) tick_cnt_d = tick_cnt_q + TICK_W'(1);
        if (mid_c) begin
          ferr_acc_d = ferr_acc_q | ~rx_s;
          bit_idx_d  = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
            done_c    = 1'b1;
            bit_idx_d = '0;
            state_d   = ferr_acc_d ? ST_BREAK : ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    hs_c    = valid_q && DATA_READY;

    if (hs_c) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done_c) begin
      if (!valid_q || hs_c) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        ferr_d  = ferr_acc_d;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_acc_q;
`else
        perr_d  = 1'b0;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  // All state, synchronizer and output registers.
  always_ff @(posedge CLK50MHz or negedge RESET) begin
    if (!RESET) begin
      sync_q     <= 2'b11;
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RX};
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      ferr_acc_q <= ferr_acc_d;
      perr_acc_q <= perr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign DATA       = data_q;
  assign DATA_VALID = valid_q;
  assign FRAME_ERR  = ferr_q;
  assign PARITY_ERR = perr_q;
  assign OVERRUN    = ovr_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_uart_rx_gen.sv
// Bench for uart_rx_gen at 50 MHz / 115200 baud, 8 data bits, 1 stop bit.
module tb_uart_rx_gen;

  localparam int unsigned CLK_HZ   = 50000000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned DIV      = CLK_HZ / (BAUD * 16);
  localparam int unsigned BIT_CLKS = DIV * 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rdy = 1'b0;
  logic [1:0] pmode = 2'd0;
  logic [7:0] data;
  logic       dv, fe, pe, ovr, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic dv_prev = 1'b0;

  uart_rx_gen #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (8),
    .STOP_BITS (1)
  ) dut (
    .CLK50MHz    (clk),
    .RESET       (rst_n),
    .RX          (rx),
    .PARITY_MODE (pmode),
    .DATA        (data),
    .DATA_VALID  (dv),
    .DATA_READY  (rdy),
    .FRAME_ERR   (fe),
    .PARITY_ERR  (pe),
    .OVERRUN     (ovr),
    .BUSY        (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    dv_prev <= dv;
    if (dv && !dv_prev) rise_cyc <= cyc;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Parity bit is on the line only in a parity build with mode even/odd.
  function automatic bit par_on(input logic [1:0] m);
    return PAR_BUILD && (m == 2'd1 || m == 2'd2);
  endfunction

  // Even: ones count including parity bit must be even; odd: must be odd.
  function automatic logic exp_perr(input logic [7:0] d, input logic [1:0] m, input logic pbit);
    int ones;
    ones = $countones(d) + (pbit ? 1 : 0);
    if (!par_on(m)) return 1'b0;
    if (m == 2'd1) return (ones % 2) != 0;
    return (ones % 2) == 0;
  endfunction

  task automatic drive_bits(input logic b, input int unsigned nclk);
    rx = b;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_lvl);
    logic bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_on(pmode)) bits.push_back(pbit);
    bits.push_back(stop_lvl);
    start_cyc = cyc;
    foreach (bits[i]) drive_bits(bits[i], BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (dv === 1'b1) break;
      @(negedge clk);
    end
    ok = (dv === 1'b1);
  endtask

  task automatic accept(input string name);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    n_tests++;
    if (dv !== 1'b0 || ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: got valid=%b overrun=%b expected 0/0", name, dv, ovr);
    end
  endtask

  task automatic check_word(input string name, input logic [7:0] d, input logic e_fe, input logic e_pe);
    bit ok;
    wait_valid(BIT_CLKS, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_valid: DATA_VALID got %b expected 1", name, dv);
    end
    n_tests++;
    if (data !== d || fe !== e_fe || pe !== e_pe) begin
      n_fail++;
      $display("FAIL %s_word: got data=%h fe=%b pe=%b expected data=%h fe=%b pe=%b",
               name, data, fe, pe, d, e_fe, e_pe);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if (data !== 8'h00 || dv !== 1'b0 || fe !== 1'b0 || pe !== 1'b0 || ovr !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got data=%h dv=%b fe=%b pe=%b ovr=%b busy=%b expected all 0",
               name, data, dv, fe, pe, ovr, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset_hold");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_8n1();
    int lat;
    pmode = 2'd0;
    send_frame(8'hA5, 1'b0, 1'b1);
    check_word("8n1_a5", 8'hA5, 1'b0, 1'b0);
    lat = rise_cyc - start_cyc;
    n_tests++;
    if (lat < int'(9 * BIT_CLKS) || lat > int'(10 * BIT_CLKS)) begin
      n_fail++;
      $display("FAIL 8n1_latency: got %0d clocks expected %0d..%0d", lat, 9 * BIT_CLKS, 10 * BIT_CLKS);
    end
    accept("8n1_a5");
  endtask

  task automatic test_parity();
    pmode = 2'd1;
    send_frame(8'h07, 1'b0, 1'b1);
    check_word("parity_bit0", 8'h07, 1'b0, exp_perr(8'h07, 2'd1, 1'b0));
    accept("parity_bit0");
    send_frame(8'h07, 1'b1, 1'b1);
    check_word("parity_bit1", 8'h07, 1'b0, exp_perr(8'h07, 2'd1, 1'b1));
    accept("parity_bit1");
    pmode = 2'd2;
    send_frame(8'h07, 1'b1, 1'b1);
    check_word("parity_odd", 8'h07, 1'b0, exp_perr(8'h07, 2'd2, 1'b1));
    accept("parity_odd");
    pmode = 2'd0;
  endtask

  task automatic test_glitch();
    drive_bits(1'b0, 3 * DIV);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_high: got %b expected 1", busy);
    end
    drive_bits(1'b1, 12 * DIV);
    n_tests++;
    if (busy !== 1'b0 || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_reject: got busy=%b dv=%b expected 0/0", busy, dv);
    end
    send_frame(8'h3C, 1'b0, 1'b1);
    check_word("glitch_next", 8'h3C, 1'b0, 1'b0);
    accept("glitch_next");
  endtask

  task automatic test_overrun();
    rdy = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    n_tests++;
    if (dv !== 1'b1 || data !== 8'h11 || ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_hold: got dv=%b data=%h ovr=%b expected 1/11/1", dv, data, ovr);
    end
    accept("overrun");
  endtask

  task automatic test_break();
    drive_bits(1'b0, 20 * BIT_CLKS);
    n_tests++;
    if (dv !== 1'b1 || data !== 8'h00 || fe !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL break_frame: got dv=%b data=%h fe=%b busy=%b expected 1/00/1/1", dv, data, fe, busy);
    end
    drive_bits(1'b1, 6);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL break_release: BUSY got %b expected 0", busy);
    end
    accept("break");
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h5A, 1'b0, 1'b1);
    check_word("pre_reset", 8'h5A, 1'b0, 1'b0);
    drive_bits(1'b0, BIT_CLKS);
    drive_bits(1'b1, 4 * BIT_CLKS + BIT_CLKS / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_midframe");
    rst_n = 1'b1;
    drive_bits(1'b1, 4 * BIT_CLKS);
    check_all_zero("reset_after_release");
    send_frame(8'h55, 1'b0, 1'b1);
    check_word("post_reset_55", 8'h55, 1'b0, 1'b0);
    accept("post_reset_55");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       pb;
    for (int k = 0; k < 4; k++) begin
      d     = 8'($urandom);
      pb    = 1'($urandom);
      pmode = 2'($urandom_range(0, 3));
      send_frame(d, pb, 1'b1);
      check_word($sformatf("random%0d", k), d, 1'b0, exp_perr(d, pmode, pb));
      accept($sformatf("random%0d", k));
    end
    pmode = 2'd0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_overrun();
    test_break();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
